// File: rtl/mux_sel_seq_pkg.sv
// Shared state encodings, select codes and slot-ordering helpers for the mux select sequencer.
package mux_sel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S10  = 3'd1,
        ST_S01  = 3'd2,
        ST_S11  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_10   = 2'b10;
    localparam logic [1:0] SEL_01   = 2'b01;
    localparam logic [1:0] SEL_11   = 2'b11;

    function automatic logic is_slot(input state_e s);
        return (s == ST_S10) || (s == ST_S01) || (s == ST_S11);
    endfunction

    function automatic logic [1:0] sel_of(input state_e s);
        logic [1:0] code;
        case (s)
            ST_S10:  code = SEL_10;
            ST_S01:  code = SEL_01;
            ST_S11:  code = SEL_11;
            default: code = SEL_NONE;
        endcase
        return code;
    endfunction

    // Slot index 0/1/2 maps to S10/S01/S11, matching mask bits 2/1/0.
    function automatic state_e slot_state(input int idx);
        state_e s;
        case (idx)
            0:       s = ST_S10;
            1:       s = ST_S01;
            default: s = ST_S11;
        endcase
        return s;
    endfunction

    function automatic state_e next_slot(input logic [2:0] mask, input state_e cur);
        state_e nxt;
        nxt = ST_DONE;
        case (cur)
            ST_IDLE: begin
                if (mask[2])      nxt = ST_S10;
                else if (mask[1]) nxt = ST_S01;
                else if (mask[0]) nxt = ST_S11;
            end
            ST_S10: begin
                if (mask[1])      nxt = ST_S01;
                else if (mask[0]) nxt = ST_S11;
            end
            ST_S01: begin
                if (mask[0])      nxt = ST_S11;
            end
            default: nxt = ST_DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mux_sel_seq_if.sv
// Run-control and mux-bank bus of the select sequencer; MUX_SEQ_PARITY_EN adds the par word.
interface mux_sel_seq_if #(
    parameter int W = 8
);
    logic         start;
    logic [2:0]   slot_en;
    logic [W-1:0] mux_out;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] res10;
    logic [W-1:0] res01;
    logic [W-1:0] res11;
`ifdef MUX_SEQ_PARITY_EN
    logic [2:0]   par;

    modport master (output start, slot_en, mux_out,
                    input  sel, busy, done, res10, res01, res11, par);
    modport slave  (input  start, slot_en, mux_out,
                    output sel, busy, done, res10, res01, res11, par);
`else
    modport master (output start, slot_en, mux_out,
                    input  sel, busy, done, res10, res01, res11);
    modport slave  (input  start, slot_en, mux_out,
                    output sel, busy, done, res10, res01, res11);
`endif
endinterface

// File: rtl/mux.sv
// Single-bit 3:1 mux cell of the bank; select 00 yields 0.
module mux (
    input  logic [1:0] sel,
    input  logic       in10,
    input  logic       in01,
    input  logic       in11,
    output logic       out
);
    always_comb begin
        case (sel)
            2'b10:   out = in10;
            2'b01:   out = in01;
            2'b11:   out = in11;
            default: out = 1'b0;
        endcase
    end
endmodule

// File: rtl/mux_sel_seq_settle_cnt.sv
// Settle counter: counts 0..SETTLE-1 while enabled, flags the final settle cycle.
module settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign last = (cnt_q == 4'(SETTLE - 1));
endmodule

// File: rtl/mux_sel_seq.sv
// Steps the mux-bank select through enabled slots, captures one result per slot, pulses done.
// Optional macro MUX_SEQ_PARITY_EN adds per-result even parity on bus.par.
module mux_sel_seq
    import mux_sel_seq_pkg::*;
#(
    parameter int W      = 8,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    mux_sel_seq_if.slave bus
);
    state_e     state_q, state_d;
    logic [2:0] mask_q, mask_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept, in_slot, cnt_clr, cnt_last;

    assign accept  = (state_q == ST_IDLE) && bus.start;
    assign in_slot = is_slot(state_q);
    assign cnt_clr = (state_d != state_q);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_d  = bus.slot_en;
                    state_d = next_slot(bus.slot_en, ST_IDLE);
                end
            end
            ST_S10, ST_S01, ST_S11: begin
                if (cnt_last) state_d = next_slot(mask_q, state_q);
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are decoded from the next state so they register alongside it.
        sel_d  = sel_of(state_d);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            sel_q   <= SEL_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    settle_cnt #(.SETTLE(SETTLE)) u_settle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (in_slot),
        .last  (cnt_last)
    );

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        logic [W-1:0] res_q, res_d;
        logic         capture;

        assign capture = (state_q == slot_state(gi)) && cnt_last;

        always_comb begin
            res_d = res_q;
            if (accept)       res_d = '0;
            else if (capture) res_d = bus.mux_out;
        end

        always_ff @(posedge clk) begin
            if (reset) res_q <= '0;
            else       res_q <= res_d;
        end
`ifdef MUX_SEQ_PARITY_EN
        logic par_q, par_d;

        always_comb begin
            par_d = par_q;
            if (accept)       par_d = 1'b0;
            else if (capture) par_d = ^bus.mux_out;
        end

        always_ff @(posedge clk) begin
            if (reset) par_q <= 1'b0;
            else       par_q <= par_d;
        end
`endif
    end

    assign bus.sel   = sel_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res10 = g_slot[0].res_q;
    assign bus.res01 = g_slot[1].res_q;
    assign bus.res11 = g_slot[2].res_q;
`ifdef MUX_SEQ_PARITY_EN
    assign bus.par   = {g_slot[0].par_q, g_slot[1].par_q, g_slot[2].par_q};
`endif
endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: three instances (SETTLE 1, 2, 3) each driving a real bank of mux cells.
module tb_mux_sel_seq;
    localparam int W = 8;

    typedef struct {
        int         inst;
        logic [2:0] mask;
        logic [7:0] p10, p01, p11;
        logic [7:0] e10, e01, e11;
        int         poke1, poke2;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p10, p01, p11;
    logic       start_a [3];
    logic [2:0] mask_a  [3];
    logic [1:0] sel_a   [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic [7:0] r10_a   [3];
    logic [7:0] r01_a   [3];
    logic [7:0] r11_a   [3];
`ifdef MUX_SEQ_PARITY_EN
    logic [2:0] par_a   [3];
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mux_sel_seq_if #(.W(W)) bus ();

        assign bus.start   = start_a[gi];
        assign bus.slot_en = mask_a[gi];

        for (genvar bi = 0; bi < W; bi++) begin : g_bank
            mux u_mux (
                .sel  (bus.sel),
                .in10 (p10[bi]),
                .in01 (p01[bi]),
                .in11 (p11[bi]),
                .out  (bus.mux_out[bi])
            );
        end

        mux_sel_seq #(.W(W), .SETTLE(gi + 1)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus.slave)
        );

        assign sel_a[gi]  = bus.sel;
        assign busy_a[gi] = bus.busy;
        assign done_a[gi] = bus.done;
        assign r10_a[gi]  = bus.res10;
        assign r01_a[gi]  = bus.res01;
        assign r11_a[gi]  = bus.res11;
`ifdef MUX_SEQ_PARITY_EN
        assign par_a[gi]  = bus.par;
`endif
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: enabled codes in fixed order, each held for s cycles starting at cycle 1.
    function automatic logic [1:0] exp_sel(input logic [2:0] m, input int s, input int c);
        logic [1:0] codes[$];
        int idx;
        if (m[2]) codes.push_back(2'b10);
        if (m[1]) codes.push_back(2'b01);
        if (m[0]) codes.push_back(2'b11);
        idx = (c - 1) / s;
        if (c >= 1 && idx < codes.size()) return codes[idx];
        return 2'b00;
    endfunction

    // Start at a negedge while idle; checks every cycle through the IDLE cycle after done.
    task automatic run(input int inst, input logic [2:0] m,
                       input logic [7:0] e10, input logic [7:0] e01, input logic [7:0] e11,
                       input int poke1, input int poke2);
        int s        = inst + 1;
        int n        = int'(m[2]) + int'(m[1]) + int'(m[0]);
        int exp_done = n * s + 1;
        int ndone    = 0;
        mask_a[inst]  = m;
        start_a[inst] = 1'b1;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            start_a[inst] = (c == poke1) || (c == poke2);
            mask_a[inst]  = 3'($urandom_range(0, 7));
            if (done_a[inst]) ndone++;
            chk($sformatf("sel i%0d m%b c%0d", inst, m, c), sel_a[inst], exp_sel(m, s, c));
            chk($sformatf("done i%0d m%b c%0d", inst, m, c), done_a[inst], (c == exp_done));
            chk($sformatf("busy i%0d m%b c%0d", inst, m, c), busy_a[inst], (c <= exp_done));
        end
        start_a[inst] = 1'b0;
        chk($sformatf("ndone i%0d m%b", inst, m), ndone, 1);
        chk($sformatf("res10 i%0d m%b", inst, m), r10_a[inst], e10);
        chk($sformatf("res01 i%0d m%b", inst, m), r01_a[inst], e01);
        chk($sformatf("res11 i%0d m%b", inst, m), r11_a[inst], e11);
`ifdef MUX_SEQ_PARITY_EN
        chk($sformatf("par i%0d m%b", inst, m), par_a[inst], {^e10, ^e01, ^e11});
`endif
        $display("run inst=%0d settle=%0d mask=%b res=%h/%h/%h pokes=%0d,%0d",
                 inst, s, m, r10_a[inst], r01_a[inst], r11_a[inst], poke1, poke2);
    endtask

    initial begin
        vec_t vecs[6];
        int   ndone;

        vecs[0] = '{inst:0, mask:3'b111, p10:8'hA5, p01:8'h3C, p11:8'hFF,
                    e10:8'hA5, e01:8'h3C, e11:8'hFF, poke1:0, poke2:0};
        vecs[1] = '{inst:2, mask:3'b101, p10:8'hA5, p01:8'h3C, p11:8'hFF,
                    e10:8'hA5, e01:8'h00, e11:8'hFF, poke1:0, poke2:0};
        vecs[2] = '{inst:0, mask:3'b000, p10:8'hA5, p01:8'h3C, p11:8'hFF,
                    e10:8'h00, e01:8'h00, e11:8'h00, poke1:0, poke2:0};
        vecs[3] = '{inst:2, mask:3'b111, p10:8'hA5, p01:8'h3C, p11:8'hFF,
                    e10:8'hA5, e01:8'h3C, e11:8'hFF, poke1:5, poke2:10};
        vecs[4] = '{inst:1, mask:3'b010, p10:8'h5A, p01:8'hC3, p11:8'h81,
                    e10:8'h00, e01:8'hC3, e11:8'h00, poke1:0, poke2:0};
        vecs[5] = '{inst:1, mask:3'b110, p10:8'h12, p01:8'h34, p11:8'h56,
                    e10:8'h12, e01:8'h34, e11:8'h00, poke1:0, poke2:0};

        rst = 1'b1;
        p10 = 8'hA5; p01 = 8'h3C; p11 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            start_a[i] = 1'b0;
            mask_a[i]  = 3'b111;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst sel i%0d", i), sel_a[i], 2'b00);
            chk($sformatf("rst busy i%0d", i), busy_a[i], 1'b0);
            chk($sformatf("rst done i%0d", i), done_a[i], 1'b0);
            chk($sformatf("rst res i%0d", i), {r10_a[i], r01_a[i], r11_a[i]}, 24'h0);
`ifdef MUX_SEQ_PARITY_EN
            chk($sformatf("rst par i%0d", i), par_a[i], 3'b000);
`endif
        end
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            p10 = vecs[v].p10; p01 = vecs[v].p01; p11 = vecs[v].p11;
            run(vecs[v].inst, vecs[v].mask, vecs[v].e10, vecs[v].e01, vecs[v].e11,
                vecs[v].poke1, vecs[v].poke2);
        end

        for (int k = 0; k < 30; k++) begin
            int         inst = $urandom_range(0, 2);
            logic [2:0] m    = 3'($urandom_range(0, 7));
            int         n;
            p10 = 8'($urandom); p01 = 8'($urandom); p11 = 8'($urandom);
            n = int'(m[2]) + int'(m[1]) + int'(m[0]);
            run(inst, m, m[2] ? p10 : 8'h00, m[1] ? p01 : 8'h00, m[0] ? p11 : 8'h00,
                $urandom_range(0, n * (inst + 1) + 1), $urandom_range(0, n * (inst + 1) + 1));
        end

        // Reset during S01 with SETTLE=2: S10 covers cycles 1-2, S01 starts in cycle 3.
        p10 = 8'hA5; p01 = 8'h3C; p11 = 8'hFF;
        mask_a[1]  = 3'b111;
        start_a[1] = 1'b1;
        @(negedge clk);
        start_a[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-rst sel", sel_a[1], 2'b01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst sel", sel_a[1], 2'b00);
        chk("midrst busy", busy_a[1], 1'b0);
        chk("midrst done", done_a[1], 1'b0);
        chk("midrst res", {r10_a[1], r01_a[1], r11_a[1]}, 24'h0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_a[1]) ndone++;
        end
        chk("midrst no done", ndone, 0);
        $display("reset mid-run inst=1 sel=%b busy=%b", sel_a[1], busy_a[1]);

`ifdef MUX_SEQ_PARITY_EN
        p10 = 8'hA5; p01 = 8'h3C; p11 = 8'h07;
        run(0, 3'b111, 8'hA5, 8'h3C, 8'h07, 0, 0);
        chk("par A5/3C/07", par_a[0], 3'b001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
